rtc_display_scan: RTL and testbench
===================================

// Module: rtc_display_scan
// PURPOSE
//  Time-multiplexed 7-segment driver, downstream of the RTC BCD counter chain.
//  - Consumes NUM_DIGITS packed BCD digits (HH:MM:SS) and scans one common-anode digit per slot.
//  - Snapshots the digits once per frame, so a digit never tears mid-frame.
//  - Inserts a blanking gap between digits to suppress ghosting.
// PARAMETERS
//  DIV        50000      clk cycles per digit slot; >= GUARD+2
//  GUARD      16         blank cycles at the start of each slot; >= 1
//  NUM_DIGITS 6          digits scanned; index 0 = rightmost (seconds units)
//  DP_MASK    6'b010100  dp lit on digit i when DP_MASK[i]=1 (HH.MM.SS separators)
// PORTS
//  clk     in   1             system clock
//  rset    in   1             synchronous, active-high reset
//  digits  in   4*NUM_DIGITS  BCD digit i = digits[4i+3:4i]
//  seg     out  7             {g,f,e,d,c,b,a}, active low
//  dp      out  1             decimal point, active low
//  an      out  NUM_DIGITS    digit anode enables, active low, at most one low
// BEHAVIOUR
//  - Single clock domain (clk). rset is synchronous and active-high.
//  - Reset values:
//    - seg=7'h7F, dp=1, an=all 1
//    - cnt=0, idx=0, shadow=0, state=BLANK
//  - Prescaler cnt runs 0..DIV-1, then wraps to 0.
//    - At cnt==DIV-1, idx advances; it wraps from NUM_DIGITS-1 to 0.
//  - Frame snapshot: shadow<=digits on the cycle where cnt==DIV-1 && idx==NUM_DIGITS-1.
//    - This is the only load point. The first frame after reset displays shadow=0.
//  - FSM, 2 states, derived per cycle:
//    - BLANK while cnt<GUARD.
//    - DRIVE while GUARD<=cnt<=DIV-1.
//    - BLANK->DRIVE at cnt==GUARD. DRIVE->BLANK at the cnt wrap.
//  - Outputs are registered and show the cnt/idx/state of the previous cycle (1-cycle latency).
//    - BLANK: an=all 1, seg=7'h7F, dp=1.
//    - DRIVE: an[idx]=0, all other an bits 1.
//      seg=decode(shadow digit idx), dp=~DP_MASK[idx].
//  - Decode values (active low):
//    - 0=40  1=79  2=24  3=30  4=19  5=12  6=02  7=78  8=00  9=10 (hex)
//    - Codes 10..15 are invalid BCD and show a dash: seg=7'h3F (g lit only).
//  - digits may change on any cycle. Changes become visible only from the next frame start.
//  - rset asserted mid-slot: the next edge forces the reset values.
//    Scanning restarts at idx=0 with a full BLANK gap first.
//  - Never two anodes low in the same cycle. Every digit transition passes through >= GUARD blank cycles.
// CONFIGURATION
//  Macro RTC_DISP_LZB_EN (leading-zero blanking):
//  - Defined: when shadow digit NUM_DIGITS-1 == 0, that digit's anode stays high in its DRIVE slot.
//    - Its seg=7'h7F and dp=1 for that slot. The slot timing is unchanged.
//  - Undefined: that digit displays '0' like any other digit.
// STRUCTURE
//  - Shared package rtc_disp_pkg:
//    - SEG_0..SEG_9, SEG_DASH, SEG_OFF constants.
//    - BLANK/DRIVE state encoding.
//  - One sub-module: bcd_to_7seg, a combinational 4-bit to 7-bit decoder built from the package constants.
//  - Top level holds the prescaler, digit index, shadow register, FSM and output registers.
// TESTING  (bench uses DIV=8, GUARD=2, NUM_DIGITS=6)
//  - Reset:
//    - Hold rset 3 cycles -> seg=7F, dp=1, an=3F.
//    - After release, first an=3E appears 3 cycles later (GUARD+1); first frame shows '0' on all digits.
//  - Scan order:
//    - digits=24'h123456 -> an cycles 3E,3D,3B,37,2F,1F, each low for 6 cycles with 2 blank cycles between.
//    - seg follows 6:02, 5:12, 4:19, 3:30, 2:24, 1:79.
//    - dp=0 only while an=3B and an=2F.
//  - No tearing: change digits from 123456 to 000000 while idx=2 -> the rest of that frame still shows 3,2,1.
//    The following frame shows 0 on all digits.
//  - Invalid BCD: digits=24'h00000A -> seg=3F during digit 0's slot.
//  - Reset mid-operation: assert rset at idx=3, cnt=5 -> next cycle all outputs off.
//    The scan restarts from idx=0 after the blank gap.
//  - With RTC_DISP_LZB_EN: digits=24'h092345 -> an never equals 1F, digit 5's slot is all blank.
//    Without the macro, an=1F with seg=40.

Source files
------------

// File: rtl/rtc_disp_pkg.sv
// Shared constants for the RTC 7-segment scanner: active-low segment
// codes {g,f,e,d,c,b,a} and the scan FSM state encoding.
package rtc_disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/rtc_display_scan_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Invalid BCD codes (10..15) render as a dash.
module bcd_to_7seg
  import rtc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/rtc_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot.
// Optional leading-zero blanking of the top digit: define RTC_DISP_LZB_EN.
module rtc_display_scan
  import rtc_disp_pkg::*;
#(
  parameter int unsigned DIV        = 50000,
  parameter int unsigned GUARD      = 16,
  parameter int unsigned NUM_DIGITS = 6,
  parameter logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100
) (
  input  logic                    clk,
  input  logic                    rset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  scan_state_e             state_q, state_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       cnt_last;
  logic       idx_last;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic       lzb_hide;

  assign cnt_last  = (cnt_q == CW'(DIV - 1));
  assign idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
  assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef RTC_DISP_LZB_EN
  assign lzb_hide = idx_last && (cur_digit == 4'd0);
`else
  assign lzb_hide = 1'b0;
`endif

  // Prescaler, digit index and the single frame-boundary snapshot point
  always_comb begin
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
      if (idx_last) begin
        shadow_d = digits;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_d == CW'(GUARD)) state_d = DRIVE;
      DRIVE:   if (cnt_last) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == DRIVE && !lzb_hide) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~DP_MASK[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      state_q  <= BLANK;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      an_q     <= '1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      state_q  <= state_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_rtc_display_scan.sv
// Self-checking bench for rtc_display_scan: frame-level model plus
// hand-computed scan points, then randomized digits and resets.
module tb_rtc_display_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int ND    = 6;
  localparam int FRAME = DIV * ND;
  localparam logic [5:0] DPM = 6'b010100;
`ifdef RTC_DISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rset = 1'b1;
  logic [23:0] digits = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;

  rtc_display_scan #(
    .DIV        (DIV),
    .GUARD      (GUARD),
    .NUM_DIGITS (ND),
    .DP_MASK    (DPM)
  ) dut (
    .clk    (clk),
    .rset   (rset),
    .digits (digits),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed   = 0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  // Model: n_m = edges since reset; display position is plain arithmetic on it
  int          n_m = 0;
  logic [23:0] sh_m = '0;
  logic [5:0]  exp_an = '1;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  bit          model_ok = 1'b0;
  int          m_cnt, m_idx;
  logic [3:0]  m_dig;

  always @(posedge clk) begin
    if (rset) begin
      n_m      = 0;
      sh_m     = '0;
      exp_an   = '1;
      exp_seg  = 7'h7F;
      exp_dp   = 1'b1;
      model_ok = 1'b1;
    end else begin
      m_cnt   = n_m % DIV;
      m_idx   = (n_m / DIV) % ND;
      m_dig   = sh_m[4*m_idx +: 4];
      exp_an  = '1;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      if (m_cnt >= GUARD && !(LZB && m_idx == ND-1 && m_dig == 4'd0)) begin
        exp_an[m_idx] = 1'b0;
        exp_seg       = seg_tab[m_dig];
        exp_dp        = ~DPM[m_idx];
      end
      n_m = n_m + 1;
      if (n_m % FRAME == 0) sh_m = digits;
    end
  end

  task automatic cmp(input string nm, input logic [13:0] got,
                     input logic [13:0] req);
    n_compared++;
    if (got !== req) begin
      n_failed++;
      $display("FAIL %s @%0t: got an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
               nm, $time, got[13:8], got[7:1], got[0],
               req[13:8], req[7:1], req[0]);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp("model", {an, seg, dp}, {exp_an, exp_seg, exp_dp});
      n_compared++;
      if ($countones(~an) > 1) begin
        n_failed++;
        $display("FAIL anode_onehot @%0t: got an=%h, required at most one low",
                 $time, an);
      end
    end
  end

  task automatic wait_n(input int k);
    int g;
    g = 0;
    while (n_m != k && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (n_m != k) begin
      n_compared++;
      n_failed++;
      $display("FAIL wait_n: got n=%0d, required n=%0d", n_m, k);
    end
  endtask

  task automatic lit(input string nm, input int k, input logic [5:0] a,
                     input logic [6:0] s, input logic d);
    wait_n(k);
    cmp(nm, {an, seg, dp}, {a, s, d});
  endtask

  initial begin
    rset   = 1'b1;
    digits = '0;
    repeat (3) @(negedge clk);
    cmp("reset_hold", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    rset   = 1'b0;
    digits = 24'h123456;

    lit("first_gap",   2, 6'h3F, 7'h7F, 1'b1);
    lit("first_zero",  3, 6'h3E, 7'h40, 1'b1);
    lit("gap_d0_d1",  57, 6'h3F, 7'h7F, 1'b1);
    lit("scan_d1",    60, 6'h3D, 7'h12, 1'b1);
    lit("scan_d2_dp", 68, 6'h3B, 7'h19, 1'b0);
    digits = 24'h000000;
    lit("tear_d3",    76, 6'h37, 7'h30, 1'b1);
    lit("tear_d5",    93, 6'h1F, 7'h79, 1'b1);
    lit("next_zero", 101, 6'h3E, 7'h40, 1'b1);
    digits = 24'h00000A;
    lit("invalid",   149, 6'h3E, 7'h3F, 1'b1);
    digits = 24'h092345;
    lit("d4_nine",   229, 6'h2F, 7'h10, 1'b0);
    if (LZB) lit("lzb_d5", 237, 6'h3F, 7'h7F, 1'b1);
    else     lit("lzb_d5", 237, 6'h1F, 7'h40, 1'b1);

    wait_n(269);
    rset = 1'b1;
    @(negedge clk);
    cmp("mid_reset", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    rset = 1'b0;
    lit("restart_gap",  1, 6'h3F, 7'h7F, 1'b1);
    lit("restart_d0",   3, 6'h3E, 7'h40, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) rset = 1'b1;
      else rset = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          digits = 24'($urandom);
        end else begin
          for (int j = 0; j < ND; j++)
            digits[4*j +: 4] = 4'($urandom_range(0, 9));
        end
      end
    end
    rset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_failed);
    $finish;
  end

endmodule
